// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode codes, sequencer state encoding and command record width
package alu_pkg;
  localparam logic [2:0] MODE_0 = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;
  localparam logic [2:0] MODE_6 = 3'd6;
  localparam logic [2:0] MODE_7 = 3'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
  function automatic int cmd_w(input int width);
    return 3 + 3 * width;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with occupancy count; pointers wrap modulo DEPTH
module cmd_fifo #(
  parameter int WIDTH_W = 15,
  parameter int DEPTH   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH_W-1:0]           din,
  output logic [WIDTH_W-1:0]           dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues one at a time on registered operands, captures results
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_sel,
  input  logic [WIDTH-1:0]            cmd_a,
  input  logic [WIDTH-1:0]            cmd_b,
  input  logic [WIDTH-1:0]            cmd_c,
  output logic [2:0]                  alu_select,
  output logic [WIDTH-1:0]            alu_a,
  output logic [WIDTH-1:0]            alu_b,
  output logic [WIDTH-1:0]            alu_c,
  input  logic [WIDTH-1:0]            alu_result,
  input  logic                        alu_carry,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [WIDTH-1:0]            res_data,
  output logic                        res_carry,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  count
);
  localparam int CW = cmd_w(WIDTH);
  localparam int LW = $clog2(ALU_LAT+1);
  logic [CW-1:0] head;
  logic full, empty, pop;
  state_t state_q, state_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [2:0] sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_data_q, res_data_d;
  logic res_valid_q, res_valid_d, res_carry_q, res_carry_d;
  cmd_fifo #(.WIDTH_W(CW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid && !full),
    .pop   (pop),
    .din   ({cmd_sel, cmd_a, cmd_b, cmd_c}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign cmd_ready  = !full;
  assign busy       = state_q != IDLE;
  assign alu_select = sel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_c      = c_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    {sel_d, a_d, b_d, c_d} = {sel_q, a_q, b_q, c_q};
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        {sel_d, a_d, b_d, c_d} = head;
        wait_d  = LW'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q - LW'(1);
        // operands have been stable ALU_LAT cycles on this edge
        if (wait_q == LW'(1)) begin
          res_data_d  = alu_result;
          res_carry_d = alu_carry;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized checks against a scoreboard and a latency-aware ALU model
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 4, DEPTH = 4, ALU_LAT = 2;
  logic clock = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0, res_carry, busy, alu_carry = 1'b0;
  logic [2:0] cmd_sel = '0, alu_select;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0, cmd_c = '0, alu_a, alu_b, alu_c, res_data;
  logic [WIDTH-1:0] alu_result = '0;
  logic [$clog2(DEPTH+1)-1:0] count;
  int n_tests = 0, n_fail = 0, cyc = 0, last_hs = -1, n_res = 0, age = 0;
  bit gap_chk = 0, rnd_on = 0;
  logic [4:0] exp_q[$];
  logic [14:0] prev_key = '0;
  logic [4:0] alu_r, held;
  always #5 clock = ~clock;
  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_result(alu_result), .alu_carry(alu_carry), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry),
    .busy(busy), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // {carry, result} of the ALU for each mode, from plain integer arithmetic
  function automatic logic [4:0] alu_f(input logic [2:0] s, input logic [3:0] a, b, c);
    int x, y, z, r;
    x = a; y = b; z = c;
    case (s)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x + y;
      3'd3: r = x - y;
      3'd4: r = x ^ y;
      3'd5: r = x + y + z;
      3'd6: r = 15 - x;
      default: r = x + z;
    endcase
    return 5'(r & 31);
  endfunction
  // ALU drives garbage until its operands have been stable long enough
  always @(posedge clock) begin
    #1;
    if ({alu_select, alu_a, alu_b, alu_c} != prev_key) age = 0;
    else if (age < 100) age++;
    prev_key = {alu_select, alu_a, alu_b, alu_c};
    alu_r = alu_f(alu_select, alu_a, alu_b, alu_c);
    {alu_carry, alu_result} = (age >= ALU_LAT - 1) ? alu_r : ~alu_r;
  end
  always @(posedge clock) cyc++;
  always @(negedge clock) begin : mon
    logic [4:0] e;
    if (res_valid && res_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h0;
      check("result", {res_carry, res_data}, e);
      if (gap_chk && last_hs >= 0) check("result_gap", cyc - last_hs, ALU_LAT + 2);
      last_hs = cyc;
      n_res++;
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [2:0] s, input logic [3:0] a, b, c);
    bit acc, ok;
    ok = 0;
    cmd_sel = s; cmd_a = a; cmd_b = b; cmd_c = c; cmd_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      acc = cmd_ready;
      step();
      if (acc) ok = 1;
    end
    cmd_valid = 1'b0;
    check("accepted", 32'(ok), 1);
    if (ok) exp_q.push_back(alu_f(s, a, b, c));
  endtask
  task automatic run_single(input logic [2:0] s, input logic [3:0] a, b, c);
    send(s, a, b, c);
    step();
    check("issue_sel", alu_select, s);
    check("issue_a", alu_a, a);
    check("issue_b", alu_b, b);
    check("issue_c", alu_c, c);
    check("busy_wait", busy, 1);
    check("valid_early1", res_valid, 0);
    step();
    check("valid_early2", res_valid, 0);
    step();
    check("valid_rise", res_valid, 1);
    check("single_data", {res_carry, res_data}, alu_f(s, a, b, c));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("valid_clear", res_valid, 0);
    check("busy_clear", busy, 0);
  endtask
  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) step();
    check("drained", exp_q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    check("rst_valid", res_valid, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_select, alu_a, alu_b, alu_c}, 0);
    check("rst_res", {res_carry, res_data}, 0);
    reset = 1'b1;
    step();
    check("rel_ready", cmd_ready, 1);
    run_single(3'd2, 4'h5, 4'h3, 4'h0);
    run_single(3'd2, 4'hF, 4'h1, 4'h0);
    check("carry_case", {res_carry, res_data}, 5'h10);
    // fill with results held back
    for (int i = 0; i < 5; i++) send(3'(i), 4'($urandom), 4'($urandom), 4'($urandom));
    check("fill_count", count, DEPTH);
    check("fill_ready", cmd_ready, 0);
    held = exp_q[0];
    cmd_sel = 3'd7; cmd_a = 4'h9; cmd_b = 4'h2; cmd_c = 4'hA; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_valid", res_valid, 1);
      check("hold_data", {res_carry, res_data}, held);
      check("stall_count", count, DEPTH);
    end
    gap_chk = 1; last_hs = -1; n_res = 0;
    res_ready = 1'b1;
    begin : accept6
      bit acc, ok;
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
        acc = cmd_ready;
        step();
        if (acc) ok = 1;
      end
      cmd_valid = 1'b0;
      check("sixth_accepted", 32'(ok), 1);
      check("sixth_count", count, DEPTH);
      if (ok) exp_q.push_back(alu_f(3'd7, 4'h9, 4'h2, 4'hA));
    end
    drain();
    check("drain_results", n_res, 6);
    gap_chk = 0;
    res_ready = 1'b0;
    // randomized traffic with random backpressure
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          step();
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    drain();
    res_ready = 1'b0;
    step();
    // abort an in-flight command with another queued
    send(3'd5, 4'h7, 4'h6, 4'h3);
    send(3'd1, 4'hC, 4'h3, 4'h0);
    reset = 1'b0;
    #1;
    check("abort_valid", res_valid, 0);
    check("abort_count", count, 0);
    check("abort_busy", busy, 0);
    check("abort_alu", {alu_select, alu_a, alu_b, alu_c}, 0);
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < ALU_LAT + 4; i++) begin
      step();
      check("post_abort_valid", res_valid, 0);
      check("post_abort_count", count, 0);
    end
    run_single(3'd5, 4'h9, 4'h4, 4'h5);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
